pipe_stage_reg: RTL and testbench

Elastic pipeline stage register for the MIPS datapath. It replaces the plain free-running stage latch between IF/ID/EX/MEM/WB with a valid/ready stage that can stall and flush. A two-entry skid buffer keeps `in_ready` a pure register output, so stall back-pressure never forms a combinational path across stages. Data width and the bubble value are parametrised, so one module serves every stage boundary.

---
 rtl/pipe_stage_reg_if.sv | 13 +
 rtl/pipe_stage_reg.sv | 57 +++++
 tb/tb_pipe_stage_reg.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle around one elastic pipeline stage
interface pipe_stage_reg_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
  modport master (output flush, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, count);
  modport slave  (input flush, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, count);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid stage with flush; PIPE_STAGE_REG_CLEAR_EN clears data to NOP on reset/flush and when empty
module pipe_stage_reg #(
  parameter int             WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP = '0
) (
  input logic clk,
  input logic reset,
  pipe_stage_reg_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             acc, pop;
  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  always_ff @(posedge clk)
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
`ifdef PIPE_STAGE_REG_CLEAR_EN
  always_ff @(posedge clk)
    if (reset) begin
      main_q <= NOP;
      skid_q <= NOP;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
`else
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
`endif
  always_comb begin
    state_d = bus.flush          ? EMPTY :
              (state_q == EMPTY) ? (acc ? ONE : EMPTY) :
              (state_q == ONE)   ? ((acc & !pop) ? TWO : (!acc & pop) ? EMPTY : ONE) :
                                   (pop ? ONE : TWO);
    main_d = (state_q == TWO && pop)                                     ? skid_q :
             ((state_q == EMPTY && acc) || (state_q == ONE && acc && pop)) ? bus.in_data : main_q;
    skid_d = (state_q == ONE && acc && !pop) ? bus.in_data : skid_q;
`ifdef PIPE_STAGE_REG_CLEAR_EN
    main_d = bus.flush ? NOP : main_d;
    skid_d = bus.flush ? NOP : skid_d;
`endif
  end
  always_comb begin
    bus.in_ready  = state_q != TWO;
    bus.out_valid = state_q != EMPTY;
    bus.count     = state_q;
`ifdef PIPE_STAGE_REG_CLEAR_EN
    bus.out_data  = bus.out_valid ? main_q : NOP;
`else
    bus.out_data  = main_q;
`endif
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus randomized queue-model scoreboard for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int W = 32;
  localparam logic [W-1:0] NOPV = 32'h0000_0020;
  logic clk = 0, reset;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.WIDTH(W)) bus ();
  pipe_stage_reg #(.WIDTH(W), .NOP(NOPV)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic rst, fl, iv;
    logic [W-1:0] d;
    logic ordy, e_ov, e_ir;
    logic [1:0] e_cnt;
    logic [W-1:0] e_d;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, fl, iv, input logic [W-1:0] d, input logic ordy, e_ov, e_ir,
                     input logic [1:0] e_cnt, input logic [W-1:0] e_d);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_ov = e_ov; r.e_ir = e_ir; r.e_cnt = e_cnt; r.e_d = e_d;
    v.push_back(r);
  endtask

  task automatic check_outputs(input string tag, input logic ov, ir, input logic [1:0] cnt, input logic [W-1:0] d);
    chk({tag, ".out_valid"}, W'(bus.out_valid), W'(ov));
    chk({tag, ".in_ready"}, W'(bus.in_ready), W'(ir));
    chk({tag, ".count"}, W'(bus.count), W'(cnt));
    if (ov) chk({tag, ".out_data"}, bus.out_data, d);
`ifdef PIPE_STAGE_REG_CLEAR_EN
    else chk({tag, ".nop"}, bus.out_data, NOPV);
`endif
  endtask

  logic [W-1:0] q[$];
  logic iv, ordy, fl, rs, acc, pop;

  initial begin
    reset = 1; bus.flush = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    add(1,0,1,32'h99,0, 0,1,0,0);
    add(1,0,1,32'h99,0, 0,1,0,0);
    for (int i = 1; i <= 8; i++) add(0,0,1,W'(i),1, 1,1,1,W'(i));
    add(0,0,0,0,1, 0,1,0,0);
    add(0,0,1,32'hA,0, 1,1,1,32'hA);
    add(0,0,1,32'hB,0, 1,0,2,32'hA);
    add(0,0,1,32'hC,0, 1,0,2,32'hA);
    add(0,0,1,32'hC,1, 1,1,1,32'hB);
    add(0,0,1,32'hC,1, 1,1,1,32'hC);
    add(0,0,0,0,1, 0,1,0,0);
    add(0,0,1,32'h11,0, 1,1,1,32'h11);
    add(0,0,1,32'h22,0, 1,0,2,32'h11);
    add(0,1,1,32'h33,0, 0,1,0,0);
    add(0,0,0,0,1, 0,1,0,0);
    add(0,0,1,32'h44,0, 1,1,1,32'h44);
    add(0,0,1,32'h45,0, 1,0,2,32'h44);
    add(1,1,1,32'h46,0, 0,1,0,0);
    add(0,0,1,32'h55,0, 1,1,1,32'h55);
    add(0,0,0,0,1, 0,1,0,0);
    add(0,0,1,32'h66,0, 1,1,1,32'h66);
    add(0,1,1,32'h77,1, 0,1,0,0);
    add(0,0,0,0,1, 0,1,0,0);
    foreach (v[i]) begin
      reset = v[i].rst; bus.flush = v[i].fl; bus.in_valid = v[i].iv;
      bus.in_data = v[i].d; bus.out_ready = v[i].ordy;
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), v[i].e_ov, v[i].e_ir, v[i].e_cnt, v[i].e_d);
    end
    reset = 0; bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      check_outputs("rand", q.size() != 0, q.size() < 2, 2'(q.size()), q.size() ? q[0] : '0);
      chk("rand.ready_full", W'(bus.in_ready && bus.count == 2), '0);
      iv = $urandom_range(0, 9) < 6;
      ordy = $urandom_range(0, 9) < 5;
      fl = $urandom_range(0, 63) == 0;
      rs = $urandom_range(0, 499) == 0;
      reset = rs; bus.flush = fl; bus.in_valid = iv; bus.out_ready = ordy;
      bus.in_data = $urandom;
      acc = iv && q.size() < 2;
      pop = ordy && q.size() != 0;
      if (rs || fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(bus.in_data);
      end
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
